// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants, types and helpers for the framebuffer scanout block.
//   H_ACTIVE/V_ACTIVE/V_TOTAL : VGA 640x480 timing (525 total lines)
//   FB_ROWS                   : framebuffer holds 128 rows, repeated down screen
//   MEM_LAT                   : fixed read latency of the framebuffer port
//   scan_state_e              : line-fetch FSM states
//   rgb444_t                  : 12-bit pixel as stored in the line buffer
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int FB_ROWS  = 128;
   localparam int MEM_LAT  = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN
   } scan_state_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Word address of pixel 0 of the framebuffer row shown on 'line'.
   function automatic logic [16:0] row_base(input logic [9:0] line);
      logic [6:0] row;
      row = 7'(line % 10'(FB_ROWS));
      return 17'(row) * 17'(H_ACTIVE);
   endfunction

endpackage

// File: rtl/fb_line_buffer.sv
// -----------------------------------------------------------------------------
// fb_line_buffer
// Two 640-pixel line banks (1280 x 12) as a simple dual-port RAM. The bank
// index is the most significant address component. Read is synchronous.
// Contents are not reset.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_bank_i  : bank written
//   wr_x_i     : pixel index written
//   wr_data_i  : pixel written
//   rd_bank_i  : bank read
//   rd_x_i     : pixel index read
//   rd_data_o  : registered read data
// -----------------------------------------------------------------------------
module fb_line_buffer
   import fb_pkg::*;
(
   input  logic       clk,
   input  logic       wr_en_i,
   input  logic       wr_bank_i,
   input  logic [9:0] wr_x_i,
   input  rgb444_t    wr_data_i,
   input  logic       rd_bank_i,
   input  logic [9:0] rd_x_i,
   output rgb444_t    rd_data_o
);

   rgb444_t mem [0:1][0:H_ACTIVE-1];

   always_ff @(posedge clk) begin
      if (wr_en_i) mem[wr_bank_i][wr_x_i] <= wr_data_i;
      rd_data_o <= mem[rd_bank_i][rd_x_i];
   end

endmodule

// File: rtl/fb_scanout.sv
// -----------------------------------------------------------------------------
// fb_scanout
// Double-buffered line scanout. While one line bank is displayed, the other
// is filled from the framebuffer with the row for the next display line.
// A line change that arrives before the fetch finished sets a sticky
// underrun flag, aborts the fetch and starts the next one.
//   CLK, RESET        : clock, asynchronous active-high reset
//   DrawX, DrawY      : current raster position
//   blank             : active-low blanking
//   mem_rd, mem_addr  : framebuffer read request / word address
//   mem_grant         : request accepted when mem_rd & mem_grant
//   mem_data          : read data, MEM_LAT cycles after acceptance ([11:0]=RGB)
//   VGA_R/G/B         : registered pixel colour
//   underrun          : sticky late-fetch flag
// Optional feature: FB_SCANOUT_BAND_MARKER_EN paints non-blanked pixels of
// every line with DrawY % 128 == 0 solid blue.
// -----------------------------------------------------------------------------
module fb_scanout
   import fb_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   output logic        mem_rd,
   output logic [16:0] mem_addr,
   input  logic        mem_grant,
   input  logic [15:0] mem_data,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B,
   output logic        underrun
);

   scan_state_e             state_q, state_d;
   logic                    bank_q, bank_d;   // bank currently displayed
   logic [9:0]              x_q, x_d;
   logic [16:0]             base_q, base_d;
   logic [MEM_LAT-1:0]      vld_q, vld_d;
   logic [MEM_LAT-1:0][9:0] xp_q, xp_d;
   logic                    under_q, under_d;
   logic [9:0]              drawy_q;
   logic                    pix_en_q;
`ifdef FB_SCANOUT_BAND_MARKER_EN
   logic                    mark_q;
`endif

   logic               line_chg, accept, fetch_start, wr_en, rd_bank;
   logic [9:0]         next_line, rd_x;
   logic [MEM_LAT-1:0] pend;
   rgb444_t            rd_pix, wr_pix, out_pix;
   logic               unused_hi;

   assign line_chg    = (DrawY != drawy_q);
   assign next_line   = (DrawY == 10'(V_TOTAL-1)) ? '0 : DrawY + 10'd1;
   assign fetch_start = line_chg && (next_line < 10'(V_ACTIVE));

   assign mem_rd   = (state_q == ST_FETCH);
   assign mem_addr = mem_rd ? base_q + 17'(x_q) : '0;
   assign accept   = mem_rd && mem_grant;

   // A return landing on a line-change cycle belongs to the aborted fetch.
   assign wr_en  = vld_q[MEM_LAT-1] && !line_chg;
   assign wr_pix = rgb444_t'(mem_data[11:0]);
   assign unused_hi = ^mem_data[15:12];

   // On a line-change cycle the bank register still points at the old line;
   // read the bank that becomes visible so pixel 0 of the new line is right.
   assign rd_bank = line_chg ? ~bank_q : bank_q;
   assign rd_x    = (DrawX < 10'(H_ACTIVE)) ? DrawX : '0;

   // Reads still outstanding beyond the one returning this cycle.
   always_comb begin
      pend = vld_q;
      pend[MEM_LAT-1] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      x_d     = x_q;
      base_d  = base_q;
      under_d = under_q;
      vld_d[0] = accept;
      xp_d[0]  = x_q;
      for (int i = 1; i < MEM_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         xp_d[i]  = xp_q[i-1];
      end

      unique case (state_q)
         ST_FETCH: begin
            if (accept) begin
               if (x_q == 10'(H_ACTIVE-1)) begin
                  state_d = ST_DRAIN;
                  x_d     = '0;
               end else begin
                  x_d = x_q + 10'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (pend == '0) state_d = ST_IDLE;
         end
         default: ;
      endcase

      // Line change wins over everything: swap banks, drop the old fetch,
      // begin the next one in the same cycle.
      if (line_chg) begin
         bank_d = ~bank_q;
         vld_d  = '0;
         x_d    = '0;
         if (state_q != ST_IDLE) under_d = 1'b1;
         if (fetch_start) begin
            state_d = ST_FETCH;
            base_d  = row_base(next_line);
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         bank_q   <= 1'b0;
         x_q      <= '0;
         base_q   <= '0;
         vld_q    <= '0;
         xp_q     <= '0;
         under_q  <= 1'b0;
         drawy_q  <= '0;
         pix_en_q <= 1'b0;
`ifdef FB_SCANOUT_BAND_MARKER_EN
         mark_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         x_q      <= x_d;
         base_q   <= base_d;
         vld_q    <= vld_d;
         xp_q     <= xp_d;
         under_q  <= under_d;
         drawy_q  <= DrawY;
         pix_en_q <= blank && (DrawX < 10'(H_ACTIVE));
`ifdef FB_SCANOUT_BAND_MARKER_EN
         mark_q   <= blank && (DrawX < 10'(H_ACTIVE)) &&
                     ((DrawY % 10'(FB_ROWS)) == 10'd0);
`endif
      end
   end

   fb_line_buffer u_lbuf (
      .clk       (CLK),
      .wr_en_i   (wr_en),
      .wr_bank_i (~bank_q),
      .wr_x_i    (xp_q[MEM_LAT-1]),
      .wr_data_i (wr_pix),
      .rd_bank_i (rd_bank),
      .rd_x_i    (rd_x),
      .rd_data_o (rd_pix)
   );

   // RAM output register plus registered enable form the 1-cycle pixel path.
   always_comb begin
      out_pix = pix_en_q ? rd_pix : '0;
`ifdef FB_SCANOUT_BAND_MARKER_EN
      if (mark_q) out_pix = '{r: 4'h0, g: 4'h0, b: 4'hF};
`endif
   end

   assign VGA_R    = out_pix.r;
   assign VGA_G    = out_pix.g;
   assign VGA_B    = out_pix.b;
   assign underrun = under_q;

endmodule
